// File: rtl/pll_lock_supervisor.sv
// Lock supervisor for the DVI rPLL: drives the PLL reset, qualifies lock, and
// releases a synchronous reset once lock is stable. Define PLL_SUP_STATUS_EN for the drop/timeout counters.
module pll_lock_supervisor #(
    parameter int unsigned LOCK_SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES      = 27,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 27000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    output logic       pll_reset,
    output logic       rst_out,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] drop_count,
    output logic [7:0] timeout_count
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam int unsigned MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    logic [LOCK_SYNC_STAGES-1:0] lock_sync_q;
    logic                        lock_s;
    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        pll_reset_q, rst_out_q, ready_q;

    // NOTE: lock is asynchronous to clk; only the last synchronizer stage may be used.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[LOCK_SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = lock_sync_q[LOCK_SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                end
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they stay in step with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= (state_d == ST_PLL_RST);
            rst_out_q   <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
        end
    end

    assign pll_reset = pll_reset_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign state     = state_q;

`ifdef PLL_SUP_STATUS_EN
    logic       timeout_hit, drop_hit;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] timeout_cnt_q, timeout_cnt_d;

    assign timeout_hit = (state_q == ST_WAIT_LOCK) && !lock_s && (cnt_q == TIMEOUT_LAST);
    assign drop_hit    = (state_q == ST_RUN) && !lock_s;

    always_comb begin
        drop_cnt_d    = drop_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        if (drop_hit && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (timeout_hit && (timeout_cnt_q != 8'hFF)) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            drop_cnt_q    <= drop_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign drop_count    = drop_cnt_q;
    assign timeout_count = timeout_cnt_q;
`else
    assign drop_count    = 8'd0;
    assign timeout_count = 8'd0;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Lock supervisor for the DVI rPLL on the GW1NR-9 board. It runs on the 27 MHz board clock and drives the rPLL `RESET` pin, and it consumes the rPLL `lock` output. It produces a debounced, synchronous reset for the pixel/TMDS logic. It also re-arms the PLL when lock never arrives or is lost.

## Interface
Parameters:
- `LOCK_SYNC_STAGES`, default 2: synchronizer flops on `lock` (≥2).
- `PLL_RST_CYCLES`, default 27: width of the `pll_reset` pulse in clk cycles (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 270000: maximum wait for lock before re-resetting the PLL (≥1).
- `LOCK_STABLE_CYCLES`, default 27000: cycles lock must stay high continuously before release (≥1).

Ports:
- `clk`, in, 1: 27 MHz board clock; the only clock.
- `reset`, in, 1: synchronous, active-high.
- `lock`, in, 1: rPLL LOCK, asynchronous to `clk`.
- `pll_reset`, out, 1: to rPLL RESET, active-high.
- `rst_out`, out, 1: active-high reset for DVI-domain logic.
- `ready`, out, 1: PLL locked and stable; equals `~rst_out`.
- `state`, out, 2: FSM state (0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN).
- `drop_count`, out, 8: saturating count of lock losses while in RUN.
- `timeout_count`, out, 8: saturating count of WAIT_LOCK timeouts.

## Operation
- `lock` passes through `LOCK_SYNC_STAGES` flops to give `lock_s`. All decisions use `lock_s`.
- There is a single down-counter-free up-counter `cnt`. Its width is clog2 of the largest parameter. `cnt` clears on every state change.
- The outputs are Moore decodes of the state register:
  - `pll_reset` = (state == PLL_RST).
  - `rst_out` = (state != RUN).
  - `ready` = (state == RUN).
- PLL_RST:
  - `cnt` increments each cycle.
  - When `cnt == PLL_RST_CYCLES-1`, go to WAIT_LOCK.
- WAIT_LOCK:
  - If `lock_s`, go to STABLE. This takes priority over timeout on the same edge.
  - Else if `cnt == LOCK_TIMEOUT_CYCLES-1`, go to PLL_RST and increment `timeout_count`.
  - Else increment `cnt`.
- STABLE:
  - If `!lock_s`, go to WAIT_LOCK. The timeout window restarts and no counter is incremented.
  - Else if `cnt == LOCK_STABLE_CYCLES-1`, go to RUN.
  - Else increment `cnt`.
- RUN:
  - If `!lock_s`, go to PLL_RST and increment `drop_count`. The PLL is always re-reset after a loss of lock.
- Counters:
  - Both counters saturate at 255.
  - Both are cleared only by `reset`.
- Reset values:
  - state = PLL_RST, `cnt` = 0, synchronizer flops = 0.
  - `pll_reset` = 1, `rst_out` = 1, `ready` = 0.
  - Both counts = 0.

## Timing
- `reset` sampled high forces reset values on that edge. While `reset` is held high, `pll_reset` and `rst_out` stay 1.
- Asserting `reset` mid-operation aborts any state immediately. It has the same effect as power-up.
- After the last edge with `reset` high, `pll_reset` stays high for exactly `PLL_RST_CYCLES` cycles.
- WAIT_LOCK lasts at most `LOCK_TIMEOUT_CYCLES` cycles.
- Edge 0 is the first edge at which `lock` is sampled high with the FSM in WAIT_LOCK. `state` becomes STABLE at edge `LOCK_SYNC_STAGES`. `ready` rises at edge `LOCK_SYNC_STAGES + LOCK_STABLE_CYCLES`.
- Lock loss in RUN: `rst_out` rises at edge `LOCK_SYNC_STAGES` after `lock` is first sampled low. `pll_reset` rises on the same edge.
- Any glitch of `lock` low lasting at least one sampled cycle during STABLE restarts the stability window.

## Configuration
- `PLL_SUP_STATUS_EN` defined:
  - `drop_count` and `timeout_count` registers are implemented as described.
- Not defined:
  - Both count outputs are constant 0 and no counter flops are built.
  - FSM, `pll_reset`, `rst_out`, `ready` and `state` behave identically in both builds.

## Test plan
Bench parameters: SYNC=2, PLL_RST=4, TIMEOUT=20, STABLE=8.

- Release `reset`, `lock` tied 0 → `pll_reset` high for 4 cycles. Then 20 cycles WAIT_LOCK. Repeats; `timeout_count` = 1, 2, 3 after each timeout.
- Release `reset`, raise `lock` 2 cycles after WAIT_LOCK entry → `ready` = 1 exactly 10 edges after first high sample. Both counts stay 0.
- In STABLE, drop `lock` for 1 cycle at cnt=5 → return to WAIT_LOCK, no PLL reset. `ready` arrives 10 edges after `lock` is resampled high.
- In RUN, drop `lock` → `rst_out`=1 and `pll_reset`=1 two edges later, `drop_count`=1. Repeat 300 times → `drop_count` saturates at 255.
- `lock` rising on the same edge as the timeout (cnt=19) → go to STABLE, `timeout_count` unchanged.
- Assert `reset` for 1 cycle while in RUN → `rst_out`=1 and state 0 on that edge. Counts are 0 (or 0 throughout with `PLL_SUP_STATUS_EN` undefined).
